// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ simple request ports onto one APB master.
// Every output is a flop; each transfer costs one SETUP cycle plus one or more ACCESS cycles.
module apb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,

  input  logic [NUM_REQ-1:0]      req,
  input  logic [32*NUM_REQ-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [32*NUM_REQ-1:0]   req_wdata,

  output logic [NUM_REQ-1:0]      ack,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [2:0]              grant_id,

  output logic [31:0]             PADDR,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [31:0]             PWDATA,
  input  logic [31:0]             PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  localparam logic [7:0]         LAST_WAIT  = 8'(TIMEOUT - 1);
  localparam logic [2:0]         LAST_RESET = 3'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ACK_ONE    = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t               state;
  logic [2:0]           last_grant;
  logic [7:0]           wait_cnt;

  logic [NUM_REQ-1:0]   eligible;
  logic                 win_valid;
  logic [2:0]           win_id;
  logic [31:0]          win_addr;
  logic                 win_write;
  logic [31:0]          win_wdata;
  logic                 timed_out;

  // A port whose ack is showing this cycle is still holding req; it must not win again.
  assign eligible  = req & ~ack;
  assign timed_out = !PREADY && (wait_cnt == LAST_WAIT);

  // Search order starts just after the last served port and wraps; first eligible hit wins.
  // NOTE: every variable gets a default before the loop so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    win_addr  = '0;
    win_write = 1'b0;
    win_wdata = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int p = 0; p < NUM_REQ; p++) begin
        if (!win_valid && eligible[p] && (p == (int'(last_grant) + k) % NUM_REQ)) begin
          win_valid = 1'b1;
          win_id    = 3'(p);
          win_addr  = req_addr[32*p +: 32];
          win_write = req_write[p];
          win_wdata = req_wdata[32*p +: 32];
        end
      end
    end
  end

  // NOTE: PRESETn is asynchronous; it kills an in-flight transfer without an ack.
  // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= S_IDLE;
      last_grant <= LAST_RESET;
      wait_cnt   <= '0;
      PADDR      <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
      ack        <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      grant_id   <= '0;
    end else begin
      ack <= '0;
      unique case (state)
        S_IDLE: begin
          if (win_valid) begin
            PADDR    <= win_addr;
            PWRITE   <= win_write;
            PWDATA   <= win_wdata;
            PSEL     <= 1'b1;
            busy     <= 1'b1;
            grant_id <= win_id;
            wait_cnt <= '0;
            state    <= S_SETUP;
          end
        end

        S_SETUP: begin
          PENABLE <= 1'b1;
          state   <= S_ACCESS;
        end

        S_ACCESS: begin
          if (PREADY || timed_out) begin
            rsp_rdata  <= (PREADY && !PWRITE) ? PRDATA : 32'h0;
            rsp_err    <= PREADY ? PSLVERR : 1'b1;
            ack        <= ACK_ONE << grant_id;
            last_grant <= grant_id;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
          if (!PREADY) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for latency, ordering, wait states, timeout and reset.
module tb_apb_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 16;

  logic                  PCLK = 1'b0;
  logic                  PRESETn = 1'b0;
  logic [NUM_REQ-1:0]    req = '0;
  logic [32*NUM_REQ-1:0] req_addr = '0;
  logic [NUM_REQ-1:0]    req_write = '0;
  logic [32*NUM_REQ-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]    ack;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  busy;
  logic [2:0]            grant_id;
  logic [31:0]           PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [31:0]           PWDATA;
  logic [31:0]           PRDATA = '0;
  logic                  PREADY = 1'b0;
  logic                  PSLVERR = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Slave behaviour knobs
  logic [31:0] slave_rdata = '0;
  logic        slave_err   = 1'b0;
  logic        slave_hang  = 1'b0;
  int          slave_waits = 0;
  int          acc_cnt     = 0;

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req(req), .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .ack(ack), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .grant_id(grant_id),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave: ready after slave_waits low cycles of each access, unless hanging.
  initial begin
    forever begin
      @(posedge PCLK);
      #1;
      if (PSEL && PENABLE) acc_cnt++;
      else acc_cnt = 0;
      PREADY  = PSEL && PENABLE && !slave_hang && (acc_cnt > slave_waits);
      PRDATA  = slave_rdata;
      PSLVERR = slave_err;
    end
  end

  // Transaction-level reference: one transfer at a time, phase 0 = setup, 1 = access.
  bit          m_active = 1'b0;
  int          m_phase  = 0;
  int          m_port   = 0;
  int          m_last   = NUM_REQ - 1;
  int          m_waits  = 0;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_wdata  = '0;
  logic        m_write  = 1'b0;
  logic [3:0]  m_ack    = '0;
  logic [3:0]  m_elig   = '0;
  logic [3:0]  m_nack   = '0;
  logic [31:0] m_rdata  = '0;
  logic        m_err    = 1'b0;
  bit          m_found  = 1'b0;

  task automatic model_done(input logic [31:0] rdata, input logic err);
    m_rdata = rdata;
    m_err   = err;
    m_nack[m_port] = 1'b1;
    m_last   = m_port;
    m_active = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge PCLK or negedge PRESETn);
      if (PRESETn !== 1'b1) begin
        m_active = 1'b0; m_phase = 0; m_port = 0; m_last = NUM_REQ - 1; m_waits = 0;
        m_addr = '0; m_wdata = '0; m_write = 1'b0; m_ack = '0; m_rdata = '0; m_err = 1'b0;
      end else begin
        m_elig = req & ~m_ack;
        m_nack = '0;
        if (!m_active) begin
          m_found = 1'b0;
          for (int k = 1; k <= NUM_REQ; k++) begin
            if (!m_found && m_elig[(m_last + k) % NUM_REQ]) begin
              m_port  = (m_last + k) % NUM_REQ;
              m_found = 1'b1;
            end
          end
          if (m_found) begin
            m_active = 1'b1;
            m_phase  = 0;
            m_waits  = 0;
            m_addr   = req_addr[32*m_port +: 32];
            m_wdata  = req_wdata[32*m_port +: 32];
            m_write  = req_write[m_port];
          end
        end else if (m_phase == 0) begin
          m_phase = 1;
        end else if (PREADY) begin
          model_done(m_write ? 32'h0 : PRDATA, PSLVERR);
        end else begin
          m_waits++;
          if (m_waits >= TIMEOUT) model_done(32'h0, 1'b1);
        end
        m_ack = m_nack;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge PCLK);
      check("psel", PSEL, m_active);
      check("penable", PENABLE, m_active && (m_phase == 1));
      check("busy", busy, m_active);
      check("ack", ack, m_ack);
      check("grant_id", grant_id, m_port);
      if (m_active) begin
        check("paddr", PADDR, m_addr);
        check("pwrite", PWRITE, m_write);
        check("pwdata", PWDATA, m_wdata);
      end
      if (m_ack != 0) begin
        check("rsp_rdata", rsp_rdata, m_rdata);
        check("rsp_err", rsp_err, m_err);
      end
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #2;
  endtask

  task automatic set_port(input int p, input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
    req_addr[32*p +: 32]  = addr;
    req_write[p]          = wr;
    req_wdata[32*p +: 32] = wdata;
  endtask

  // Counts cycles from the next sampling edge until ack shows; also tracks access cycles
  // and whether PADDR ever leaves exp_addr while selected. Optionally scrambles a port's
  // inputs after the latch.
  int          cyc, nacc, bad;
  logic [3:0]  got;
  logic [31:0] rd;
  logic        er;

  task automatic wait_ack(input int max, input int scramble, input logic [31:0] exp_addr);
    cyc = 0; nacc = 0; bad = 0; got = '0; rd = '0; er = 1'b0;
    while (cyc < max && got == 0) begin
      @(posedge PCLK);
      @(negedge PCLK);
      cyc++;
      if (PENABLE) nacc++;
      if (PSEL && PADDR !== exp_addr) bad++;
      if (scramble >= 0 && cyc == 2) begin
        req_addr[32*scramble +: 32]  = ~req_addr[32*scramble +: 32];
        req_wdata[32*scramble +: 32] = ~req_wdata[32*scramble +: 32];
        req_write[scramble]          = ~req_write[scramble];
      end
      if (ack != 0) begin
        got = ack;
        rd  = rsp_rdata;
        er  = rsp_err;
      end
    end
    check("ack_seen", got != 0, 1'b1);
    check("paddr_stable", bad, 0);
  endtask

  function automatic int idx_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  int exp_order [5] = '{0, 1, 2, 3, 0};
  int guard;

  initial begin
    // Reset state
    repeat (3) @(negedge PCLK);
    check("rst_psel", PSEL, 1'b0);
    check("rst_ack", ack, 4'b0000);
    check("rst_grant", grant_id, 3'd0);
    check("rst_busy", busy, 1'b0);
    tick();
    PRESETn = 1'b1;
    tick();

    // Single write, zero wait
    set_port(0, 32'h1000_0004, 1'b1, 32'hDEAD_BEEF);
    req[0] = 1'b1;
    wait_ack(10, -1, 32'h1000_0004);
    check("wr_latency", cyc, 3);
    check("wr_access_cycles", nacc, 1);
    check("wr_ack", got, 4'b0001);
    check("wr_err", er, 1'b0);
    tick();
    req[0] = 1'b0;
    tick();
    tick();

    // Read from port 2
    slave_rdata = 32'hCAFE_BABE;
    set_port(2, 32'h1000_0008, 1'b0, 32'h0);
    req[2] = 1'b1;
    wait_ack(10, -1, 32'h1000_0008);
    check("rd_ack", got, 4'b0100);
    check("rd_data", rd, 32'hCAFE_BABE);
    check("rd_err", er, 1'b0);
    tick();
    req[2] = 1'b0;
    tick();

    // Write with slave error: data forced to zero, error passed through
    slave_rdata = 32'h1234_5678;
    slave_err   = 1'b1;
    set_port(1, 32'h2000_0010, 1'b1, 32'h0BAD_F00D);
    req[1] = 1'b1;
    wait_ack(10, -1, 32'h2000_0010);
    check("slverr_ack", got, 4'b0010);
    check("slverr_rdata", rd, 32'h0);
    check("slverr_err", er, 1'b1);
    tick();
    req[1]    = 1'b0;
    slave_err = 1'b0;
    tick();

    // Five wait states, requester inputs scrambled after the latch
    slave_waits = 5;
    set_port(3, 32'h3000_0000, 1'b1, 32'h5555_AAAA);
    req[3] = 1'b1;
    wait_ack(20, 3, 32'h3000_0000);
    check("ws_latency", cyc, 8);
    check("ws_access_cycles", nacc, 6);
    check("ws_ack", got, 4'b1000);
    check("ws_err", er, 1'b0);
    tick();
    req[3]      = 1'b0;
    slave_waits = 0;
    tick();

    // Contention: all ports held, expect 0,1,2,3,0 three cycles apart
    slave_rdata = 32'h0000_A5A5;
    for (int p = 0; p < NUM_REQ; p++) set_port(p, 32'h5000_0000 | (p << 4), 1'b0, 32'h0);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_ack(10, -1, 32'h5000_0000 | (exp_order[n] << 4));
      check("rr_order", idx_of(got), exp_order[n]);
      check("rr_spacing", cyc, 3);
    end
    tick();
    req   = 4'b0000;
    guard = 0;
    do begin
      @(negedge PCLK);
      guard++;
    end while ((busy || ack != 0) && guard < 20);
    check("rr_drained", busy || ack != 0, 1'b0);
    tick();

    // Timeout: slave never ready
    slave_hang = 1'b1;
    set_port(3, 32'h4000_0000, 1'b0, 32'h0);
    req[3] = 1'b1;
    wait_ack(40, -1, 32'h4000_0000);
    check("to_latency", cyc, TIMEOUT + 2);
    check("to_access_cycles", nacc, TIMEOUT);
    check("to_ack", got, 4'b1000);
    check("to_err", er, 1'b1);
    check("to_rdata", rd, 32'h0);
    check("to_idle", busy, 1'b0);
    tick();
    req[3] = 1'b0;
    tick();

    // Reset during ACCESS on port 1; port 0 must go first afterwards
    set_port(0, 32'h6000_0000, 1'b1, 32'h0000_0001);
    set_port(1, 32'h6000_0004, 1'b1, 32'h0000_0002);
    tick();
    req[1] = 1'b1;
    repeat (3) begin
      @(posedge PCLK);
      @(negedge PCLK);
    end
    check("pre_rst_penable", PENABLE, 1'b1);
    req[0] = 1'b1;
    tick();
    PRESETn = 1'b0;
    #1;
    check("rst_mid_psel", PSEL, 1'b0);
    check("rst_mid_penable", PENABLE, 1'b0);
    check("rst_mid_ack", ack, 4'b0000);
    tick();
    tick();
    PRESETn    = 1'b1;
    slave_hang = 1'b0;
    wait_ack(10, -1, 32'h6000_0000);
    check("post_rst_first", got, 4'b0001);
    check("post_rst_latency", cyc, 3);
    tick();
    req[0] = 1'b0;
    wait_ack(10, -1, 32'h6000_0004);
    check("post_rst_second", got, 4'b0010);
    tick();
    req[1] = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_rr_arbiter.md
APB_RR_ARBITER -- requirements
Module: apb_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requester ports, range 2..8.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum PREADY=0 cycles in ACCESS before forced termination, range 1..255.
REQ-003 SHALL have PCLK  input  1: clock; all logic on rising edge.
REQ-004 SHALL have PRESETn  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have req  input  NUM_REQ: per-port transfer request, level, held until that port's ack.
REQ-006 SHALL have req_addr  input  32*NUM_REQ: per-port address, port i at bits [32i+31:32i].
REQ-007 SHALL have req_write  input  NUM_REQ: per-port direction, 1=write, 0=read.
REQ-008 SHALL have req_wdata  input  32*NUM_REQ: per-port write data, same packing as req_addr.
REQ-009 SHALL have ack  output  NUM_REQ: one-hot, single-cycle completion pulse to the served port.
REQ-010 SHALL have rsp_rdata  output  32: read data, valid while ack is high.
REQ-011 SHALL have rsp_err  output  1: error flag, valid while ack is high.
REQ-012 SHALL have busy  output  1: high in SETUP and ACCESS.
REQ-013 SHALL have grant_id  output  3: index of the port being served; holds the last value when idle.
REQ-014 SHALL have APB master outputs PADDR 32, PSEL 1, PENABLE 1, PWRITE 1, PWDATA 32.
REQ-015 SHALL have APB master inputs PRDATA 32, PREADY 1, PSLVERR 1.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP and ACCESS, all outputs registered.
REQ-017 IDLE, any eligible req: SHALL select a winner, latch its addr/write/wdata into PADDR/PWRITE/PWDATA, set PSEL=1, grant_id=winner, and go to SETUP.
REQ-018 Round-robin: SHALL search from port (last_grant+1) mod NUM_REQ upward with wrap; lowest index in that order wins.
REQ-019 SHALL update last_grant to the winner on completion; reset value NUM_REQ-1, so port 0 has first priority.
REQ-020 SETUP: SHALL set PENABLE=1 and go to ACCESS unconditionally (exactly one SETUP cycle).
REQ-021 ACCESS, PREADY=1: SHALL set rsp_rdata=PRDATA for reads, or 0 for writes; set rsp_err=PSLVERR; pulse ack[grant_id]; clear PSEL/PENABLE; go to IDLE.
REQ-022 ACCESS, PREADY=0: SHALL increment an 8-bit wait counter, which is cleared on entry to SETUP.
REQ-023 Timeout: when the wait counter reaches TIMEOUT with PREADY still 0, SHALL complete with rsp_err=1 and rsp_rdata=0, pulse ack, and go to IDLE.
REQ-024 PADDR, PWRITE and PWDATA SHALL stay stable from SETUP through the end of ACCESS; requester inputs SHALL be ignored after the latch.
REQ-025 In the IDLE cycle where ack[i]=1, SHALL mask req[i] from arbitration so a requester may drop req one cycle after seeing ack.
REQ-026 Zero-wait latency: req sampled in IDLE at edge N gives SETUP after N, ACCESS after N+1, and ack high after N+2; back-to-back transfers take 3 cycles each.
REQ-027 req changes on non-granted ports during a transfer SHALL have no effect until the next IDLE.
REQ-028 PSEL SHALL never be high with PENABLE high for more than one completing cycle, and PENABLE SHALL never rise without a preceding SETUP cycle.

Reset
REQ-029 On PRESETn=0, immediately and regardless of state: SHALL go to IDLE; all outputs 0; last_grant=NUM_REQ-1; wait counter 0.
REQ-030 Reset mid-transfer SHALL drop the transfer with no ack generated; after release, a still-asserted req SHALL be re-arbitrated from IDLE.

Verification
REQ-031 Single write: req[0]=1, addr 0x1000_0004, wdata 0xDEADBEEF, PREADY=1 -> SETUP/ACCESS visible on bus, ack[0] 3 cycles after req, rsp_err=0.
REQ-032 Read: req[2] read of 0x1000_0008, slave PRDATA=0xCAFEBABE -> rsp_rdata=0xCAFEBABE while ack[2]=1.
REQ-033 Contention: all 4 req held after reset -> grant order 0,1,2,3,0; each ack 3 cycles apart.
REQ-034 Wait states: PREADY low 5 ACCESS cycles -> PADDR/PWDATA stable throughout, ack on cycle 6 of ACCESS, rsp_err=0.
REQ-035 Timeout: PREADY held 0 with TIMEOUT=16 -> ack after 16 wait cycles, rsp_err=1, rsp_rdata=0, FSM back in IDLE.
REQ-036 Reset in ACCESS: PRESETn pulsed low -> PSEL=PENABLE=0 immediately, no ack, port 0 served first after release.
